// File: rtl/uart_pkg.sv
// Shared UART transmitter types and defaults.
// Optional parity support is selected by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: one-cycle tick on the last clk_i cycle of every serial bit.
// Part of uart_tx (optional parity via UART_TX_PARITY_EN has no effect here).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST_CNT) && !clr_i;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from the read side of an async FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  re_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif
    logic                  baud_clr;
    logic                  tick;

    assign re_o     = (state_q == ST_IDLE) && enable_i && !empty_i && !rst_i;
    assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_FETCH);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE:  if (re_o) state_d = ST_FETCH;
            ST_FETCH: begin
                shift_d   = rdata_i;
                bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                par_d     = ^rdata_i;
`endif
                state_d   = ST_START;
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Line level is derived from the next state so the registered tx_o lines up with state_q.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // The pop cycle is part of the frame envelope, so busy spans one full word period.
    assign tx_o   = tx_q;
    assign busy_o = busy_q || re_o;

endmodule
